// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the receive-side datapath.
//   - aes_dec_state_e  : FSM states of the iterative inverse cipher
//   - INV_SBOX         : inverse S-box, byte i at bits [8i:8i+7]
//   - fn_xtime         : multiply by {02} in GF(2^8), poly x^8+x^4+x^3+x+1
//   - fn_inv_sub_bytes, fn_inv_shift_rows, fn_inv_mix_columns
// State vectors are [0:127] with byte k at bits [8k:8k+7], column-major:
// byte k sits in column k/4, row k%4.
// These live here so the GCM decrypt path and key-unwrap can reuse them.
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_dec_state_e;

    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] fn_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] fn_inv_sub_bytes(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = INV_SBOX[{s[8*k +: 8], 3'b000} +: 8];
        end
        return r;
    endfunction

    // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [0:127] fn_inv_shift_rows(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[8*(4*c + row) +: 8] = s[8*(4*((c - row + 4) % 4) + row) +: 8];
            end
        end
        return r;
    endfunction

    // Each column is multiplied by the circulant matrix {0e,0b,0d,09},
    // built from xtime chains: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
    function automatic logic [0:127] fn_inv_mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a  [4];
        logic [7:0]   x2 [4];
        logic [7:0]   x4 [4];
        logic [7:0]   x8 [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i]  = s[8*(4*c + i) +: 8];
                x2[i] = fn_xtime(a[i]);
                x4[i] = fn_xtime(x2[i]);
                x8[i] = fn_xtime(x4[i]);
            end
            for (int i = 0; i < 4; i++) begin
                r[8*(4*c + i) +: 8] =
                    (x8[i]         ^ x4[i]         ^ x2[i])           ^
                    (x8[(i+1) % 4] ^ x2[(i+1) % 4] ^ a[(i+1) % 4])    ^
                    (x8[(i+2) % 4] ^ x4[(i+2) % 4] ^ a[(i+2) % 4])    ^
                    (x8[(i+3) % 4] ^ a[(i+3) % 4]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse-cipher round.
//   state       : current 128-bit state
//   round_key   : round key for this round
//   final_round : 1 = last round, InvMixColumns skipped
//   next_state  : result of the round
// ---------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [0:127] state,
    input  logic [0:127] round_key,
    input  logic         final_round,
    output logic [0:127] next_state
);

    logic [0:127] keyed;

    assign keyed      = fn_inv_sub_bytes(fn_inv_shift_rows(state)) ^ round_key;
    assign next_state = final_round ? keyed : fn_inv_mix_columns(keyed);

endmodule

// File: rtl/aes_decrypt_iterative.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iterative
// Iterative AES-128 inverse cipher, one round per clock.
//   clk, rst        : clock, asynchronous active-high reset
//   i_valid/o_ready : ciphertext handshake (o_ready only in IDLE)
//   i_cipher_text   : ciphertext block, byte k at bits [8k:8k+7]
//   i_key_schedule  : 11 round keys, key r at bits [128r:128r+127]
//   i_phase         : sideband tag returned with the result
//   o_valid/i_ready : plaintext handshake (o_valid only in DONE)
//   o_plain_text    : recovered plaintext
//   o_phase         : tag captured at accept
// Accept at edge E0, rounds on E1..E10, result held in DONE until drained.
// ---------------------------------------------------------------------------
module aes_decrypt_iterative
    import aes_pkg::*;
#(
    parameter int NR   = 10,
    parameter int KS_W = 128 * (NR + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [0:127]    i_cipher_text,
    input  logic [0:KS_W-1] i_key_schedule,
    input  logic [0:2]      i_phase,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [0:127]    o_plain_text,
    output logic [0:2]      o_phase
);

    aes_dec_state_e  state_q;
    aes_dec_state_e  state_d;
    logic [3:0]      round_cnt;
    logic [0:127]    data_q;
    logic [0:KS_W-1] key_q;
    logic [0:2]      phase_q;
    logic [0:127]    round_key;
    logic [0:127]    round_out;
    logic            accept;

    assign accept = (state_q == IDLE) && i_valid;

    // Round keys come from the latched copy so the schedule input may change
    // freely once the block is accepted. Counter values above NR never occur.
    assign round_key = key_q[{round_cnt, 7'd0} +: 128];

    aes_inv_round u_round (
        .state       (data_q),
        .round_key   (round_key),
        .final_round (round_cnt == 4'd0),
        .next_state  (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            round_cnt <= 4'd0;
            data_q    <= '0;
            key_q     <= '0;
            phase_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Initial AddRoundKey with rk NR happens on the accept edge.
                data_q    <= i_cipher_text ^ i_key_schedule[NR*128 +: 128];
                key_q     <= i_key_schedule;
                phase_q   <= i_phase;
                round_cnt <= 4'(NR - 1);
            end else if (state_q == ROUND) begin
                data_q <= round_out;
                if (round_cnt != 4'd0) begin
                    round_cnt <= round_cnt - 4'd1;
                end
            end
        end
    end

    // Next state and state-decoded outputs; nothing here depends
    // combinationally on i_valid or i_ready for o_ready/o_valid.
    always_comb begin
        state_d      = state_q;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_plain_text = '0;
        o_phase      = '0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (round_cnt == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid      = 1'b1;
                o_plain_text = data_q;
                o_phase      = phase_q;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_iterative
// Self-checking bench for aes_decrypt_iterative. Expected plaintexts come
// from FIPS-197 vectors or from a forward AES-128 model (S-box derived from
// GF(2^8) inversion plus the affine map) that encrypts random plaintexts.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_iterative;

    logic           clk;
    logic           rst;
    logic           i_valid;
    logic           o_ready;
    logic [0:127]   i_cipher_text;
    logic [0:1407]  i_key_schedule;
    logic [0:2]     i_phase;
    logic           o_valid;
    logic           i_ready;
    logic [0:127]   o_plain_text;
    logic [0:2]     o_phase;

    int compare_count  = 0;
    int mismatch_count = 0;
    int cycle          = 0;

    logic [7:0]    sbox [256];
    logic [0:127]  blk_ct [16];
    logic [0:127]  blk_pt [16];
    logic [0:1407] blk_ks [16];
    logic [0:2]    blk_ph [16];
    int            accept_edge [16];
    int            drain_edge  [16];

    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_iterative dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_cipher_text  (i_cipher_text),
        .i_key_schedule (i_key_schedule),
        .i_phase        (i_phase),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_plain_text   (o_plain_text),
        .o_phase        (o_phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] key_expand(input logic [0:127] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                     ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [0:127] model_encrypt(input logic [0:127] pt,
                                                   input logic [0:1407] ks);
        logic [0:127] s;
        logic [0:127] t;
        logic [7:0]   a [4];
        s = pt ^ ks[0 +: 128];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[8*k +: 8] = sbox[s[8*k +: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[8*(4*c + row) +: 8] = t[8*(4*((c + row) % 4) + row) +: 8];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) a[i] = s[8*(4*c + i) +: 8];
                    for (int i = 0; i < 4; i++)
                        s[8*(4*c + i) +: 8] = gf_mul(a[i], 8'h02)
                                            ^ gf_mul(a[(i+1) % 4], 8'h03)
                                            ^ a[(i+2) % 4] ^ a[(i+3) % 4];
                end
            end
            s = s ^ ks[128*r +: 128];
        end
        return s;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [0:1407] rand_ks();
        logic [0:1407] k;
        for (int i = 0; i < 44; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    task automatic drive_garbage();
        i_cipher_text  = rand128();
        i_key_schedule = rand_ks();
        i_phase        = 3'($urandom_range(0, 7));
    endtask

    // Presents one block until o_ready is seen, returns the accept edge
    // number; afterwards the inputs carry random garbage with i_valid low.
    task automatic applyStimulus(input logic [0:127] ct, input logic [0:1407] ks,
                                 input logic [0:2] ph, output int acc);
        int budget;
        budget = 50;
        acc    = -1;
        while (budget > 0) begin
            @(negedge clk);
            budget--;
            i_cipher_text  = ct;
            i_key_schedule = ks;
            i_phase        = ph;
            i_valid        = 1'b1;
            if (o_ready) begin
                acc = cycle + 1;
                break;
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        drive_garbage();
        checkOutput("accept_seen", 128'((acc >= 0) ? 1 : 0), 128'd1);
    endtask

    // Streams blk_*[0..n-1] through the DUT, checking results in order.
    task automatic run_stream(input int n, input bit random_ready, input bit random_gaps);
        int sent;
        int got;
        int budget;
        sent   = 0;
        got    = 0;
        budget = 40 * n + 40;
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            i_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && i_ready) begin
                checkOutput("stream_pt", o_plain_text, blk_pt[got]);
                checkOutput("stream_phase", 128'(o_phase), 128'(blk_ph[got]));
                drain_edge[got] = cycle + 1;
                got++;
            end
            if (sent < n && !(random_gaps && $urandom_range(0, 3) == 0)) begin
                i_cipher_text  = blk_ct[sent];
                i_key_schedule = blk_ks[sent];
                i_phase        = blk_ph[sent];
                i_valid        = 1'b1;
            end else begin
                drive_garbage();
                i_valid = 1'b0;
            end
            if (i_valid && o_ready) begin
                accept_edge[sent] = cycle + 1;
                sent++;
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        checkOutput("stream_count", 128'(got), 128'(n));
    endtask

    initial begin
        int acc;
        int lat;
        int hits;
        logic [0:1407] c1_ks;
        logic [0:1407] b_ks;
        logic [0:127]  key;

        build_sbox();
        c1_ks = key_expand(C1_KEY);
        b_ks  = key_expand(B_KEY);

        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        drive_garbage();
        #2;
        checkOutput("reset_valid", 128'(o_valid), 128'd0);
        checkOutput("reset_ready", 128'(o_ready), 128'd1);
        checkOutput("reset_pt", o_plain_text, 128'd0);
        checkOutput("reset_phase", 128'(o_phase), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] FIPS-197 C.1 with input corruption after accept");
        blk_ct[0] = C1_CT; blk_ks[0] = c1_ks; blk_ph[0] = 3'b101; blk_pt[0] = C1_PT;
        run_stream(1, 1'b0, 1'b0);

        $display("[TB] FIPS-197 Appendix B");
        blk_ct[0] = B_CT; blk_ks[0] = b_ks; blk_ph[0] = 3'b010; blk_pt[0] = B_PT;
        run_stream(1, 1'b0, 1'b0);

        $display("[TB] backpressure");
        i_ready = 1'b0;
        applyStimulus(C1_CT, c1_ks, 3'b011, acc);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (o_valid) begin
                lat = cycle - acc + 1;
                break;
            end
            @(negedge clk);
            drive_garbage();
        end
        checkOutput("bp_latency", 128'(lat), 128'd11);
        for (int n = 0; n < 20; n++) begin
            checkOutput("bp_valid", 128'(o_valid), 128'd1);
            checkOutput("bp_ready", 128'(o_ready), 128'd0);
            checkOutput("bp_pt", o_plain_text, C1_PT);
            checkOutput("bp_phase", 128'(o_phase), 128'd3);
            drive_garbage();
            i_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", 128'(o_ready), 128'd1);
        checkOutput("bp_release_valid", 128'(o_valid), 128'd0);
        i_ready = 1'b0;

        $display("[TB] back-to-back");
        blk_ct[0] = C1_CT; blk_ks[0] = c1_ks; blk_ph[0] = 3'b101; blk_pt[0] = C1_PT;
        blk_ct[1] = B_CT;  blk_ks[1] = b_ks;  blk_ph[1] = 3'b110; blk_pt[1] = B_PT;
        run_stream(2, 1'b0, 1'b0);
        checkOutput("b2b_latency", 128'(drain_edge[0] - accept_edge[0]), 128'd11);
        checkOutput("b2b_reaccept", 128'(accept_edge[1] - drain_edge[0]), 128'd1);
        checkOutput("b2b_spacing", 128'(accept_edge[1] - accept_edge[0]), 128'd12);
        checkOutput("b2b_drain_spacing", 128'(drain_edge[1] - drain_edge[0]), 128'd12);

        $display("[TB] reset mid-round");
        applyStimulus(C1_CT, c1_ks, 3'b111, acc);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 128'(o_valid), 128'd0);
        checkOutput("midrst_ready", 128'(o_ready), 128'd1);
        checkOutput("midrst_pt", o_plain_text, 128'd0);
        checkOutput("midrst_phase", 128'(o_phase), 128'd0);
        @(negedge clk);
        rst  = 1'b0;
        hits = 0;
        i_ready = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (o_valid) hits++;
        end
        i_ready = 1'b0;
        checkOutput("midrst_dropped", 128'(hits), 128'd0);
        blk_ct[0] = C1_CT; blk_ks[0] = c1_ks; blk_ph[0] = 3'b101; blk_pt[0] = C1_PT;
        run_stream(1, 1'b0, 1'b0);

        $display("[TB] random blocks against forward model");
        for (int i = 0; i < 8; i++) begin
            key       = rand128();
            blk_ks[i] = key_expand(key);
            blk_pt[i] = rand128();
            blk_ct[i] = model_encrypt(blk_pt[i], blk_ks[i]);
            blk_ph[i] = 3'($urandom_range(0, 7));
        end
        run_stream(8, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
